bf_stage_seq: RTL

Radix-2 single-path delay-feedback (SDF) stage sequencer for the pipelined FFT. It owns the phase counter and the M-entry feedback buffer, and it steers each accepted sample into one of two paths: the buffer, or the add/sub-and-halve butterfly datapath. It emits the butterfly sum outputs in the current frame and the difference outputs in the following frame. It sits between two FFT stages and tags difference outputs with a twiddle index for the downstream twiddle multiplier.

---
 rtl/bf_stage_seq.sv | 104 ++++++++++
 1 files changed

// File: rtl/bf_stage_seq.sv
// bf_stage_seq: radix-2 SDF butterfly stage sequencer for the pipelined FFT.
// Owns the phase counter and the M-entry feedback buffer. It emits butterfly
// sums in the current frame and the difference terms, tagged for the twiddle
// multiplier, in the following frame.
// Optional build macro: BF_ROUND_HALF_UP_EN enables round-half-up before the
// halving shift. Without it the shift truncates toward minus infinity.
module bf_stage_seq #(
    parameter int WIDTH = 16,
    parameter int LOG_M = 2
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             di_en,
    input  logic [WIDTH-1:0] di_re,
    input  logic [WIDTH-1:0] di_im,
    output logic             do_en,
    output logic [WIDTH-1:0] do_re,
    output logic [WIDTH-1:0] do_im,
    output logic             do_tw_en,
    output logic [LOG_M-1:0] do_tw_idx
);

    localparam int unsigned M  = 1 << LOG_M;
    localparam int unsigned CW = LOG_M + 1;
    localparam int unsigned DW = 2 * WIDTH;
    localparam int unsigned SW = WIDTH + 1;

    logic [CW-1:0]    cnt;
    logic             primed;
    logic [DW-1:0]    mem [M];

    logic [LOG_M-1:0] n_c;
    logic             phase_c;
    logic [WIDTH-1:0] x0_re_c, x0_im_c;
    logic [WIDTH-1:0] y0_re_c, y0_im_c, y1_re_c, y1_im_c;

    // Halve a WIDTH+1-bit sum/difference; the kept low WIDTH bits of the
    // logical and the arithmetic shift are identical.
    function automatic logic [WIDTH-1:0] halve(input logic [SW-1:0] s);
        logic [SW-1:0] t;
`ifdef BF_ROUND_HALF_UP_EN
        t = s + SW'(1);
`else
        t = s;
`endif
        return WIDTH'(t >> 1);
    endfunction

    // Sign-extend a component to the butterfly working width.
    function automatic logic [SW-1:0] sext(input logic [WIDTH-1:0] v);
        return {v[WIDTH-1], v};
    endfunction

    // Buffer read and butterfly arithmetic for the current sample.
    always_comb begin
        n_c     = cnt[LOG_M-1:0];
        phase_c = cnt[LOG_M];
        x0_re_c = mem[n_c][DW-1:WIDTH];
        x0_im_c = mem[n_c][WIDTH-1:0];
        y0_re_c = halve(sext(x0_re_c) + sext(di_re));
        y0_im_c = halve(sext(x0_im_c) + sext(di_im));
        y1_re_c = halve(sext(x0_re_c) - sext(di_re));
        y1_im_c = halve(sext(x0_im_c) - sext(di_im));
    end

    // Feedback buffer: store the raw input in phase 0 and the difference in phase 1.
    always_ff @(posedge clock) begin
        if (!reset && di_en) begin
            if (phase_c) begin
                mem[n_c] <= {y1_re_c, y1_im_c};
            end else begin
                mem[n_c] <= {di_re, di_im};
            end
        end
    end

    // Phase counter, primed flag and registered outputs.
    always_ff @(posedge clock) begin
        if (reset) begin
            cnt       <= '0;
            primed    <= 1'b0;
            do_en     <= 1'b0;
            do_re     <= '0;
            do_im     <= '0;
            do_tw_en  <= 1'b0;
            do_tw_idx <= '0;
        end else begin
            do_en    <= di_en & primed;
            do_tw_en <= di_en & primed & ~phase_c;
            if (di_en) begin
                cnt <= cnt + CW'(1);
                if (cnt == CW'(M - 1)) begin
                    primed <= 1'b1;
                end
                if (primed) begin
                    do_re     <= phase_c ? y0_re_c : x0_re_c;
                    do_im     <= phase_c ? y0_im_c : x0_im_c;
                    do_tw_idx <= n_c;
                end
            end
        end
    end

endmodule
